// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC engine: arctangent table, FSM encoding,
// mode constants and the gain-compensation factor callers use to pre-scale x.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic ROT = 1'b0;
    localparam logic VEC = 1'b1;

    // 1/An (about 0.607253) as Q2.30.
    localparam logic [31:0] INV_AN_Q230 = 32'h26DD_3B6A;

    // atan(2^-i) as a binary angle where 2^32 is one full turn.
    function automatic logic [31:0] atan_lut(input logic [4:0] i);
        logic [31:0] a;
        case (i)
            5'd0:  a = 32'h2000_0000;
            5'd1:  a = 32'h12E4_051D;
            5'd2:  a = 32'h09FB_385B;
            5'd3:  a = 32'h0511_11D4;
            5'd4:  a = 32'h028B_0D43;
            5'd5:  a = 32'h0145_D7E1;
            5'd6:  a = 32'h00A2_F61E;
            5'd7:  a = 32'h0051_7C55;
            5'd8:  a = 32'h0028_BE53;
            5'd9:  a = 32'h0014_5F2E;
            5'd10: a = 32'h000A_2F98;
            5'd11: a = 32'h0005_17CC;
            5'd12: a = 32'h0002_8BE6;
            5'd13: a = 32'h0001_45F3;
            5'd14: a = 32'h0000_A2F9;
            5'd15: a = 32'h0000_517C;
            5'd16: a = 32'h0000_28BE;
            5'd17: a = 32'h0000_145F;
            5'd18: a = 32'h0000_0A2F;
            5'd19: a = 32'h0000_0517;
            5'd20: a = 32'h0000_028B;
            5'd21: a = 32'h0000_0145;
            5'd22: a = 32'h0000_00A2;
            5'd23: a = 32'h0000_0051;
            5'd24: a = 32'h0000_0028;
            5'd25: a = 32'h0000_0014;
            5'd26: a = 32'h0000_000A;
            5'd27: a = 32'h0000_0005;
            5'd28: a = 32'h0000_0002;
            5'd29: a = 32'h0000_0001;
            default: a = 32'h0000_0000;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic_micro_rot.sv
// One combinational CORDIC micro-rotation at the internal datapath width,
// steering toward z=0 (rotation) or y=0 (vectoring).
module cordic_micro_rot #(
    parameter int W     = 16,
    parameter int GUARD = 2,
    parameter int IW    = W + GUARD + 1
) (
    input  logic [IW-1:0] x_i,
    input  logic [IW-1:0] y_i,
    input  logic [IW-1:0] z_i,
    input  logic [4:0]    iter_i,
    input  logic          mode_i,
    output logic [IW-1:0] x_o,
    output logic [IW-1:0] y_o,
    output logic [IW-1:0] z_o
);
    import cordic_pkg::*;

    logic signed [IW-1:0] x_shr;
    logic signed [IW-1:0] y_shr;
    logic        [IW-1:0] atan_step;
    logic                 d_pos;

    assign x_shr = $signed(x_i) >>> iter_i;
    assign y_shr = $signed(y_i) >>> iter_i;

    // Table is scaled so that 2^(W+GUARD) internal LSBs make one full turn.
    assign atan_step = IW'(atan_lut(iter_i) >> (32 - (W + GUARD)));

    assign d_pos = (mode_i == VEC) ? y_i[IW-1] : ~z_i[IW-1];

    always_comb begin
        x_o = x_i;
        y_o = y_i;
        z_o = z_i;
        if (d_pos) begin
            x_o = x_i - $unsigned(y_shr);
            y_o = y_i + $unsigned(x_shr);
            z_o = z_i - atan_step;
        end else begin
            x_o = x_i + $unsigned(y_shr);
            y_o = y_i - $unsigned(x_shr);
            z_o = z_i + atan_step;
        end
    end

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: quadrant pre-rotation on accept, one micro-rotation per
// clock, then rounded/saturated x/y and wrapped z held until the consumer takes them.
module cordic_iter #(
    parameter int W     = 16,
    parameter int ITER  = 14,
    parameter int GUARD = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic [W-1:0] z_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic [W-1:0] z_out
);
    import cordic_pkg::*;

    localparam int IW = W + GUARD + 1;
    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);
    localparam logic [IW:0] RND = (GUARD == 0) ? '0 : ((IW + 1)'(1) << (GUARD - 1));

    if (ITER < 1 || ITER > W - 1) begin : g_bad_iter
        $error("cordic_iter: ITER must lie in 1..W-1");
    end
    if (W + GUARD > 32) begin : g_bad_width
        $error("cordic_iter: W+GUARD must not exceed the 32-bit angle table");
    end

    state_e        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          mode_q;
    logic [4:0]    cnt_q;
    logic [IW-1:0] x_q, y_q, z_q;
    logic [IW-1:0] x_d, y_d, z_d;
    logic [W-1:0]  x_out_q, y_out_q, z_out_q;

    logic          flip;
    logic [W-1:0]  z_pre_w;
    logic [IW-1:0] x_ext, y_ext, x_pre, y_pre, z_pre;

    // Inputs sign-extended by one bit so negating -2^(W-1) stays representable.
    assign x_ext   = {{(GUARD + 1){x_in[W-1]}}, x_in} << GUARD;
    assign y_ext   = {{(GUARD + 1){y_in[W-1]}}, y_in} << GUARD;
    assign flip    = (mode == VEC) ? x_in[W-1] : (z_in[W-1] ^ z_in[W-2]);
    assign z_pre_w = {z_in[W-1] ^ flip, z_in[W-2:0]};
    assign z_pre   = {{(GUARD + 1){z_pre_w[W-1]}}, z_pre_w} << GUARD;
    assign x_pre   = flip ? -x_ext : x_ext;
    assign y_pre   = flip ? -y_ext : y_ext;

    cordic_micro_rot #(
        .W     (W),
        .GUARD (GUARD),
        .IW    (IW)
    ) u_micro_rot (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .iter_i (cnt_q),
        .mode_i (mode_q),
        .x_o    (x_d),
        .y_o    (y_d),
        .z_o    (z_d)
    );

    logic [IW-1:0] xy_d   [2];
    logic [W-1:0]  xy_sat [2];

    assign xy_d[0] = x_d;
    assign xy_d[1] = y_d;

    // Round half-up at the guard bits, then clamp to the W-bit signed range.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sat
        logic [IW:0] sum;
        logic [IW:0] shr;
        logic        fits;
        assign sum  = {xy_d[gi][IW-1], xy_d[gi]} + RND;
        assign shr  = $unsigned($signed(sum) >>> GUARD);
        assign fits = (&shr[IW:W-1]) | ~(|shr[IW:W-1]);
        assign xy_sat[gi] = fits ? shr[W-1:0] : {shr[IW], {(W - 1){~shr[IW]}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mode_q      <= ROT;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            z_out_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_ready_q && in_valid) begin
                        in_ready_q <= 1'b0;
                        mode_q     <= mode;
                        x_q        <= x_pre;
                        y_q        <= y_pre;
                        z_q        <= z_pre;
                        cnt_q      <= '0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    x_q   <= x_d;
                    y_q   <= y_d;
                    z_q   <= z_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        x_out_q     <= xy_sat[0];
                        y_out_q     <= xy_sat[1];
                        z_out_q     <= z_d[W+GUARD-1:GUARD];
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A same-cycle in_valid is deliberately not taken until IDLE.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign z_out     = z_out_q;

endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter: rotation, quadrant pre-rotation, vectoring,
// saturation, backpressure and asynchronous reset abort.
module tb_cordic_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        mode = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
    logic [15:0] z_in = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] x_out;
    logic [15:0] y_out;
    logic [15:0] z_out;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    cordic_iter #(.W(16), .ITER(14), .GUARD(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp,
                             input int tol, input bit wrap);
        int  d;
        logic in_tol;
        d = obs - exp;
        if (wrap) d = int'(shortint'(d));
        in_tol = (d <= tol) && (d >= -tol);
        n_total++;
        assert (in_tol === 1'b1) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, tol);
        end
    endtask

    function automatic int sv(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic start_op(input string tag, input logic m, input int xv, input int yv, input int zv);
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq({tag, "_in_ready"}, int'(in_ready), 1);
        mode = m;
        x_in = 16'(xv);
        y_in = 16'(yv);
        z_in = 16'(zv);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge (inclusive) to the edge that raises out_valid.
    task automatic wait_result(input string tag);
        int lat;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, lat, 15);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic m, input int xv, input int yv, input int zv,
                         input int ex, input int ey, input int ez);
        start_op(tag, m, xv, yv, zv);
        wait_result(tag);
        check_tol({tag, "_x"}, sv(x_out), ex, 4, 1'b0);
        check_tol({tag, "_y"}, sv(y_out), ey, 4, 1'b0);
        check_tol({tag, "_z"}, sv(z_out), ez, 2, 1'b1);
        release_result();
    endtask

    initial begin
        logic [15:0] hx, hy, hz;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", int'(in_ready), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_x_out", sv(x_out), 0);
        check_eq("rst_y_out", sv(y_out), 0);
        check_eq("rst_z_out", sv(z_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_in_ready", int'(in_ready), 1);

        // Rotation and quadrant pre-rotation
        do_op("rot30", 1'b0, 9949, 0, 5461, 14189, 8192, 0);
        do_op("rot150", 1'b0, 9949, 0, 27307, -14189, 8192, 0);
        do_op("rotm120", 1'b0, 9949, 0, -21845, -8192, -14189, 0);

        // Vectoring
        do_op("vec45", 1'b1, 8192, 8192, 0, 19078, 0, 8192);
        do_op("vec180", 1'b1, -8192, 0, 0, 13490, 0, -32768);

        // Saturation
        start_op("sat", 1'b0, 32767, 32767, 0);
        wait_result("sat");
        check_tol("sat_x", sv(x_out), 32767, 4, 1'b0);
        check_eq("sat_y", sv(y_out), 32767);
        release_result();

        // Backpressure: hold the result, ignore a pending operand
        start_op("bp", 1'b0, 9949, 0, 5461);
        wait_result("bp");
        hx = x_out; hy = y_out; hz = z_out;
        mode = 1'b1; x_in = 16'd8192; y_in = 16'd8192; z_in = 16'd0;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check_eq("bp_out_valid", int'(out_valid), 1);
            check_eq("bp_in_ready", int'(in_ready), 0);
            check_eq("bp_x_stable", sv(x_out), sv(hx));
            check_eq("bp_y_stable", sv(y_out), sv(hy));
            check_eq("bp_z_stable", sv(z_out), sv(hz));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("bp_release_out_valid", int'(out_valid), 0);
        check_eq("bp_release_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("bp_accept_in_ready", int'(in_ready), 0);
        wait_result("bp2");
        check_tol("bp2_x", sv(x_out), 19078, 4, 1'b0);
        check_tol("bp2_z", sv(z_out), 8192, 2, 1'b1);
        release_result();

        // Reset mid-run (during iteration 5) aborts asynchronously
        start_op("rstrun", 1'b0, 9949, 0, 27307);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", int'(out_valid), 0);
        check_eq("abort_x_out", sv(x_out), 0);
        check_eq("abort_y_out", sv(y_out), 0);
        check_eq("abort_z_out", sv(z_out), 0);
        check_eq("abort_in_ready", int'(in_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_rel_in_ready", int'(in_ready), 1);
        check_eq("abort_rel_out_valid", int'(out_valid), 0);
        do_op("after_rst", 1'b0, 9949, 0, -21845, -8192, -14189, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
